// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared USB constants, the IN packetizer state encoding and the byte-wide
// CRC16 step used by both the IN packetizer and the OUT depacketizer.
// No ports (package).
// -----------------------------------------------------------------------------
package usb_pkg;

    localparam logic [7:0]  PID_DATA0    = 8'hC3;
    localparam logic [7:0]  PID_DATA1    = 8'h4B;
    localparam logic [7:0]  PID_ACK      = 8'hD2;
    localparam logic [7:0]  PID_NAK      = 8'h5A;
    localparam logic [7:0]  PID_STALL    = 8'h1E;

    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PID     = 3'd1,
        ST_DATA    = 3'd2,
        ST_CRC_LO  = 3'd3,
        ST_CRC_HI  = 3'd4,
        ST_WAIT_HS = 3'd5
    } pkt_state_e;

    // One byte of reflected CRC16, bits consumed LSB first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC16_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_in_packetizer_if.sv
// -----------------------------------------------------------------------------
// usb_in_packetizer_if
// Bundles the endpoint FIFO read side and the byte stream towards the SIE
// transmitter.
//   fifo_q/fifo_empty/fifo_rdreq : show-ahead FIFO read port
//   tx_data/tx_valid/tx_ready/tx_last : valid/ready byte stream to the SIE
// master = packetizer side, slave = FIFO + SIE side.
// -----------------------------------------------------------------------------
interface usb_in_packetizer_if;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic       fifo_rdreq;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        input  fifo_q, fifo_empty, tx_ready,
        output fifo_rdreq, tx_data, tx_valid, tx_last
    );

    modport slave (
        output fifo_q, fifo_empty, tx_ready,
        input  fifo_rdreq, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/usb_crc16.sv
// -----------------------------------------------------------------------------
// usb_crc16
// Running USB CRC16 register with byte-wide update.
//   i_clk, i_reset (sync, active low) ; i_clr reloads the init value ;
//   i_en folds i_data into the CRC ; o_crc is the current register.
// -----------------------------------------------------------------------------
module usb_crc16
    import usb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);
    logic [15:0] r_crc;

    // CRC register: clear has priority over an update.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_crc <= CRC16_INIT;
        end else if (i_clr) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_next(r_crc, i_data);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/usb_in_packetizer.sv
// -----------------------------------------------------------------------------
// usb_in_packetizer
// Drains one IN-endpoint FIFO into USB DATA0/DATA1 packets (PID, payload,
// CRC16), keeps the last packet for retransmission until ACKed, answers NAK
// when empty and STALL when halted.
//   i_clk, i_reset (sync, active low)
//   io_bus       : FIFO read port + SIE byte stream (master modport)
//   i_in_token   : IN token pulse      i_hs_ack / i_hs_timeout : handshake result
//   i_stall      : endpoint halted     i_toggle_clr : force DATA0, drop pending
//   o_busy       : state != IDLE
// -----------------------------------------------------------------------------
module usb_in_packetizer
    import usb_pkg::*;
#(
    parameter int MAX_PKT = 8,
    parameter int CNT_W   = $clog2(MAX_PKT) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    usb_in_packetizer_if.master io_bus,
    input  logic                i_in_token,
    input  logic                i_hs_ack,
    input  logic                i_hs_timeout,
    input  logic                i_stall,
    input  logic                i_toggle_clr,
    output logic                o_busy
);
    localparam int               AW      = CNT_W - 1;
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_PKT);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_PID     = ST_PID;
    localparam logic [2:0] S_DATA    = ST_DATA;
    localparam logic [2:0] S_CRC_LO  = ST_CRC_LO;
    localparam logic [2:0] S_CRC_HI  = ST_CRC_HI;
    localparam logic [2:0] S_WAIT_HS = ST_WAIT_HS;

    logic [2:0]       r_state;
    logic             r_toggle;
    logic             r_pending;
    logic             r_retx;       // 1: replay r_buf, 0: pull from FIFO
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic [7:0]       r_buf [MAX_PKT];
    logic             r_hs_valid;   // one-byte NAK/STALL reply outstanding
    logic [7:0]       r_hs_byte;
    logic             r_clr_latched;

    logic             w_tx_valid;
    logic             w_tx_last;
    logic [7:0]       w_tx_data;
    logic             w_accept;
    logic             w_rdreq;
    logic             w_pend_eff;
    logic [15:0]      w_crc;

    // A toggle_clr arriving with the token wins: the token then sees no pending.
    assign w_pend_eff = r_pending & ~i_toggle_clr;

    // Byte source selection for the SIE stream.
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_tx_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hs_valid) begin
                    w_tx_valid = 1'b1;
                    w_tx_data  = r_hs_byte;
                    w_tx_last  = 1'b1;
                end else begin
                    w_tx_valid = 1'b0;
                end
            end
            S_PID: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_toggle ? PID_DATA1 : PID_DATA0;
            end
            S_DATA: begin
                if (r_retx) begin
                    if (r_idx < r_len) begin
                        w_tx_valid = 1'b1;
                        w_tx_data  = r_buf[r_idx[AW-1:0]];
                    end else begin
                        w_tx_valid = 1'b0;
                    end
                end else begin
                    if ((r_len < LEN_MAX) && !io_bus.fifo_empty) begin
                        w_tx_valid = 1'b1;
                        w_tx_data  = io_bus.fifo_q;
                    end else begin
                        w_tx_valid = 1'b0;
                    end
                end
            end
            S_CRC_LO: begin
                w_tx_valid = 1'b1;
                w_tx_data  = ~w_crc[7:0];
            end
            S_CRC_HI: begin
                w_tx_valid = 1'b1;
                w_tx_data  = ~w_crc[15:8];
                w_tx_last  = 1'b1;
            end
            default: begin
                w_tx_valid = 1'b0;
            end
        endcase
    end

    assign w_accept = w_tx_valid & io_bus.tx_ready;
    assign w_rdreq  = w_accept & (r_state == S_DATA) & ~r_retx;

    assign io_bus.tx_valid   = w_tx_valid;
    assign io_bus.tx_data    = w_tx_data;
    assign io_bus.tx_last    = w_tx_last;
    assign io_bus.fifo_rdreq = w_rdreq;
    assign o_busy            = (r_state != S_IDLE);

    usb_crc16 u_crc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_accept && (r_state == S_PID)),
        .i_en    (w_accept && (r_state == S_DATA)),
        .i_data  (w_tx_data),
        .o_crc   (w_crc)
    );

    // Payload copy for retransmission; only entries below r_len are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_rdreq) begin
            r_buf[r_len[AW-1:0]] <= io_bus.fifo_q;
        end else begin
            r_buf <= r_buf;
        end
    end

    // Packet sequencing, data toggle and retransmit bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_toggle      <= 1'b0;
            r_pending     <= 1'b0;
            r_retx        <= 1'b0;
            r_len         <= '0;
            r_idx         <= '0;
            r_hs_valid    <= 1'b0;
            r_hs_byte     <= 8'h00;
            r_clr_latched <= 1'b0;
        end else begin
            // toggle_clr during transmission is deferred to the packet end.
            if (i_toggle_clr && (r_state != S_IDLE) && (r_state != S_WAIT_HS)) begin
                r_clr_latched <= 1'b1;
            end else begin
                r_clr_latched <= r_clr_latched;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_toggle_clr) begin
                        r_toggle  <= 1'b0;
                        r_pending <= 1'b0;
                    end else begin
                        r_toggle  <= r_toggle;
                    end
                    if (r_hs_valid) begin
                        if (w_accept) begin
                            r_hs_valid <= 1'b0;
                        end else begin
                            r_hs_valid <= 1'b1;
                        end
                    end else if (i_in_token) begin
                        if (i_stall) begin
                            r_hs_valid <= 1'b1;
                            r_hs_byte  <= PID_STALL;
                        end else if (w_pend_eff) begin
                            r_retx  <= 1'b1;
                            r_idx   <= '0;
                            r_state <= S_PID;
                        end else if (io_bus.fifo_empty) begin
                            r_hs_valid <= 1'b1;
                            r_hs_byte  <= PID_NAK;
                        end else begin
                            r_retx  <= 1'b0;
                            r_len   <= '0;
                            r_state <= S_PID;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PID: begin
                    if (w_accept) begin
                        r_state <= S_DATA;
                    end else begin
                        r_state <= S_PID;
                    end
                end
                S_DATA: begin
                    if (!w_tx_valid) begin
                        r_state <= S_CRC_LO;
                    end else if (w_accept) begin
                        if (r_retx) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            r_len <= r_len + 1'b1;
                        end
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_CRC_LO: begin
                    if (w_accept) begin
                        r_state <= S_CRC_HI;
                    end else begin
                        r_state <= S_CRC_LO;
                    end
                end
                S_CRC_HI: begin
                    if (w_accept) begin
                        if (r_clr_latched || i_toggle_clr) begin
                            r_toggle      <= 1'b0;
                            r_pending     <= 1'b0;
                            r_clr_latched <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_pending <= 1'b1;
                            r_state   <= S_WAIT_HS;
                        end
                    end else begin
                        r_state <= S_CRC_HI;
                    end
                end
                S_WAIT_HS: begin
                    // A token here means the host gave up on the handshake:
                    // behave as a timeout followed by an IDLE token.
                    if (i_toggle_clr) begin
                        r_toggle  <= 1'b0;
                        r_pending <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (i_in_token) begin
                        if (i_stall) begin
                            r_hs_valid <= 1'b1;
                            r_hs_byte  <= PID_STALL;
                            r_state    <= S_IDLE;
                        end else begin
                            r_retx  <= 1'b1;
                            r_idx   <= '0;
                            r_state <= S_PID;
                        end
                    end else if (i_hs_ack) begin
                        r_toggle  <= ~r_toggle;
                        r_pending <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (i_hs_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT_HS;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_in_packetizer.sv
// -----------------------------------------------------------------------------
// tb_usb_in_packetizer
// Self-checking bench: a queue-level packet model (PID/toggle/pending rules,
// bit-serial CRC16 over the whole payload) predicts every byte the SIE side
// must see; a simple array FIFO feeds the DUT.
// -----------------------------------------------------------------------------
module tb_usb_in_packetizer;
    localparam int MAX_PKT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_token, hs_ack, hs_timeout, stall, toggle_clr, busy;
    logic zlp_hook;

    usb_in_packetizer_if bus();

    // Bench-side FIFO.
    logic [7:0]  fmem [0:1023];
    logic [15:0] frd = 16'd0;
    logic [15:0] fwr = 16'd0;
    assign bus.fifo_empty = (frd == fwr) || zlp_hook;
    assign bus.fifo_q     = fmem[frd[9:0]];
    always @(posedge clk) if (bus.fifo_rdreq) frd <= frd + 16'd1;

    usb_in_packetizer #(.MAX_PKT(MAX_PKT)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .io_bus       (bus),
        .i_in_token   (in_token),
        .i_hs_ack     (hs_ack),
        .i_hs_timeout (hs_timeout),
        .i_stall      (stall),
        .i_toggle_clr (toggle_clr),
        .o_busy       (busy)
    );

    // Capture of accepted bytes and stall-stability monitor (sampled on negedge).
    logic [7:0] got_d [0:4095];
    logic       got_l [0:4095];
    int gcnt = 0, rdcnt = 0, stab_bad = 0;
    logic p_v = 1'b0, p_r = 1'b0, p_l = 1'b0, p_rst = 1'b0;
    logic [7:0] p_d = 8'h00;
    always @(negedge clk) begin
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            got_d[gcnt] <= bus.tx_data;
            got_l[gcnt] <= bus.tx_last;
            gcnt        <= gcnt + 1;
        end
        if (rst_n && bus.fifo_rdreq) rdcnt <= rdcnt + 1;
        if (p_rst && rst_n && p_v && !p_r &&
            (!bus.tx_valid || bus.tx_data !== p_d || bus.tx_last !== p_l))
            stab_bad <= stab_bad + 1;
        p_v   <= bus.tx_valid;
        p_r   <= bus.tx_ready;
        p_d   <= bus.tx_data;
        p_l   <= bus.tx_last;
        p_rst <= rst_n;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic       m_toggle, m_pending;
    logic [7:0] m_payload [$];
    logic [7:0] exp_q [$];

    task automatic build_pkt();
        logic [15:0] c;
        logic        fb;
        exp_q.push_back(m_toggle ? 8'h4B : 8'hC3);
        c = 16'hFFFF;
        foreach (m_payload[i]) begin
            exp_q.push_back(m_payload[i]);
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ m_payload[i][j];
                c  = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
            end
        end
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
    endtask

    task automatic model_token(input logic zlp);
        exp_q = {};
        if (stall) begin
            exp_q.push_back(8'h1E);
        end else if (m_pending) begin
            build_pkt();
        end else if (frd == fwr) begin
            exp_q.push_back(8'h5A);
        end else begin
            m_payload = {};
            if (!zlp)
                for (int i = 0; i < MAX_PKT && (frd + 16'(i)) != fwr; i++)
                    m_payload.push_back(fmem[10'(frd + 16'(i))]);
            build_pkt();
            m_pending = 1'b1;
        end
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[fwr[9:0]] = 8'($urandom);
            fwr = fwr + 16'd1;
        end
    endtask

    task automatic push_val(input logic [7:0] v);
        fmem[fwr[9:0]] = v;
        fwr = fwr + 16'd1;
    endtask

    task automatic pulse_ack();
        hs_ack = 1'b1; @(posedge clk); #1; hs_ack = 1'b0;
        m_toggle = ~m_toggle; m_pending = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_tmo();
        hs_timeout = 1'b1; @(posedge clk); #1; hs_timeout = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue a token and compare the resulting byte stream against the model.
    task automatic token(input string tag, input logic zlp, input logic bp);
        int   start;
        logic done;
        model_token(zlp);
        start = gcnt;
        in_token = 1'b1; @(posedge clk); #1; in_token = 1'b0;
        if (zlp) zlp_hook = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (gcnt > start && got_l[gcnt-1]) done = 1'b1;
            else begin
                @(posedge clk); #1;
                if (bp) bus.tx_ready = 1'($urandom_range(0, 1));
            end
        end
        bus.tx_ready = 1'b1;
        zlp_hook = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_len"}, 32'(gcnt - start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < gcnt - start; i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(got_d[start+i]), 32'(exp_q[i]));
            chk($sformatf("%s_l%0d", tag, i), 32'(got_l[start+i]),
                32'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        int rd0, start;
        logic done;
        rst_n = 1'b0; in_token = 1'b0; hs_ack = 1'b0; hs_timeout = 1'b0;
        stall = 1'b0; toggle_clr = 1'b0; zlp_hook = 1'b0; bus.tx_ready = 1'b1;
        m_toggle = 1'b0; m_pending = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_last",  32'(bus.tx_last),  32'd0);
        chk("rst_data",  32'(bus.tx_data),  32'd0);
        chk("rst_rdreq", 32'(bus.fifo_rdreq), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-length DATA0: FIFO hidden after the token.
        push_val(8'h00);
        token("zlp", 1'b1, 1'b0);
        pulse_ack();

        // Packet build: FIFO 00 01 02 03 (the 00 is left from above).
        push_val(8'h01); push_val(8'h02); push_val(8'h03);
        rd0 = rdcnt;
        token("build", 1'b0, 1'b0);
        chk("build_rdreq", 32'(rdcnt - rd0), 32'd4);
        pulse_ack();

        // Segmentation: 10 bytes -> 8 + 2, then NAK.
        push_rand(10);
        token("seg1", 1'b0, 1'b0);
        pulse_ack();
        token("seg2", 1'b0, 1'b0);
        pulse_ack();
        token("nak", 1'b0, 1'b0);
        chk("nak_busy", 32'(busy), 32'd0);

        // Retransmit after timeout, then via a token during WAIT_HS.
        push_rand(3);
        token("rt_a", 1'b0, 1'b0);
        pulse_tmo();
        rd0 = rdcnt;
        token("rt_b", 1'b0, 1'b0);
        chk("rt_rdreq", 32'(rdcnt - rd0), 32'd0);
        token("rt_c", 1'b0, 1'b0);
        pulse_ack();
        push_rand(2);
        token("rt_d", 1'b0, 1'b0);
        pulse_ack();

        // Backpressure.
        push_rand(6);
        token("bp", 1'b0, 1'b1);
        pulse_ack();

        // Randomized traffic.
        for (int it = 0; it < 6; it++) begin
            push_rand($urandom_range(1, 12));
            token($sformatf("rnd%0d", it), 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                pulse_tmo();
                token($sformatf("rnd%0d_rt", it), 1'b0, 1'b0);
            end
            pulse_ack();
        end

        // STALL has priority, state untouched.
        stall = 1'b1;
        token("stall", 1'b0, 1'b0);
        stall = 1'b0;

        // toggle_clr in IDLE drops a pending retransmit.
        push_rand(4);
        token("tc_a", 1'b0, 1'b0);
        pulse_tmo();
        toggle_clr = 1'b1; @(posedge clk); #1; toggle_clr = 1'b0;
        m_toggle = 1'b0; m_pending = 1'b0;
        token("tc_b", 1'b0, 1'b0);
        pulse_ack();

        // Reset in the middle of DATA.
        push_rand(8);
        start = gcnt;
        in_token = 1'b1; @(posedge clk); #1; in_token = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (gcnt - start >= 3) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_reached", 32'(done), 32'd1);
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        m_toggle = 1'b0; m_pending = 1'b0;
        @(posedge clk); #1;
        token("post_rst", 1'b0, 1'b0);
        pulse_ack();

        chk("stable", 32'(stab_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
